// File: rtl/exp7_pkg.sv
// rtl/exp7_pkg.sv - state codes and widths for the experiment 7 control unit
package exp7_pkg;

  localparam int STATE_W = 5;

  localparam logic [STATE_W-1:0] ST_INICIAL        = 5'h00;
  localparam logic [STATE_W-1:0] ST_PREPARACAO     = 5'h01;
  localparam logic [STATE_W-1:0] ST_INICIO_RODADA  = 5'h02;
  localparam logic [STATE_W-1:0] ST_MOSTRA_LED     = 5'h03;
  localparam logic [STATE_W-1:0] ST_PROXIMO_LED    = 5'h04;
  localparam logic [STATE_W-1:0] ST_FIM_EXIBICAO   = 5'h05;
  localparam logic [STATE_W-1:0] ST_ESPERA_JOGADA  = 5'h06;
  localparam logic [STATE_W-1:0] ST_REGISTRA       = 5'h07;
  localparam logic [STATE_W-1:0] ST_COMPARACAO     = 5'h08;
  localparam logic [STATE_W-1:0] ST_PROXIMA_JOGADA = 5'h09;
  localparam logic [STATE_W-1:0] ST_ULTIMA_OK      = 5'h0A;
  localparam logic [STATE_W-1:0] ST_ESPERA_NOVA    = 5'h0B;
  localparam logic [STATE_W-1:0] ST_REGISTRA_NOVA  = 5'h0C;
  localparam logic [STATE_W-1:0] ST_GRAVA          = 5'h0D;
  localparam logic [STATE_W-1:0] ST_PROXIMA_RODADA = 5'h0E;
  localparam logic [STATE_W-1:0] ST_FIM_ACERTOU    = 5'h10;
  localparam logic [STATE_W-1:0] ST_FIM_ERROU      = 5'h11;
  localparam logic [STATE_W-1:0] ST_FIM_TIMEOUT    = 5'h12;

  typedef enum logic [STATE_W-1:0] {
    S_INICIAL        = ST_INICIAL,
    S_PREPARACAO     = ST_PREPARACAO,
    S_INICIO_RODADA  = ST_INICIO_RODADA,
    S_MOSTRA_LED     = ST_MOSTRA_LED,
    S_PROXIMO_LED    = ST_PROXIMO_LED,
    S_FIM_EXIBICAO   = ST_FIM_EXIBICAO,
    S_ESPERA_JOGADA  = ST_ESPERA_JOGADA,
    S_REGISTRA       = ST_REGISTRA,
    S_COMPARACAO     = ST_COMPARACAO,
    S_PROXIMA_JOGADA = ST_PROXIMA_JOGADA,
    S_ULTIMA_OK      = ST_ULTIMA_OK,
    S_ESPERA_NOVA    = ST_ESPERA_NOVA,
    S_REGISTRA_NOVA  = ST_REGISTRA_NOVA,
    S_GRAVA          = ST_GRAVA,
    S_PROXIMA_RODADA = ST_PROXIMA_RODADA,
    S_FIM_ACERTOU    = ST_FIM_ACERTOU,
    S_FIM_ERROU      = ST_FIM_ERROU,
    S_FIM_TIMEOUT    = ST_FIM_TIMEOUT
  } state_e;

endpackage

// File: rtl/exp7_unidade_controle_if.sv
// rtl/exp7_unidade_controle_if.sv - control/status bundle between control unit and datapath
interface exp7_unidade_controle_if;
  import exp7_pkg::*;

  // start request and datapath status
  logic iniciar;
  logic jogada_correta;
  logic enderecoIgualRodada;
  logic fimL;
  logic jogada_feita;
  logic timeout;
  logic leds_fim;

  // datapath control strobes
  logic zeraCR;
  logic zeraE;
  logic contaCR;
  logic contaE;
  logic limpaRC;
  logic registraRC;
  logic zeraLeds;
  logic registraLeds;
  logic contaT;
  logic contaL;
  logic led_selector;
  logic led_turn_off;
  logic ram_enable;

  // game result flags and debug state
  logic pronto;
  logic ganhou;
  logic perdeu;
  logic db_timeout;
  logic [STATE_W-1:0] db_estado;

  modport master (
    input  iniciar, jogada_correta, enderecoIgualRodada, fimL, jogada_feita, timeout, leds_fim,
    output zeraCR, zeraE, contaCR, contaE, limpaRC, registraRC, zeraLeds, registraLeds,
    output contaT, contaL, led_selector, led_turn_off, ram_enable,
    output pronto, ganhou, perdeu, db_timeout, db_estado
  );

  modport slave (
    output iniciar, jogada_correta, enderecoIgualRodada, fimL, jogada_feita, timeout, leds_fim,
    input  zeraCR, zeraE, contaCR, contaE, limpaRC, registraRC, zeraLeds, registraLeds,
    input  contaT, contaL, led_selector, led_turn_off, ram_enable,
    input  pronto, ganhou, perdeu, db_timeout, db_estado
  );

endinterface

// File: rtl/exp7_unidade_controle.sv
// rtl/exp7_unidade_controle.sv - Moore FSM sequencing the memory game; EXP7_UC_TIMEOUT_EN enables move timeout
module exp7_unidade_controle
  import exp7_pkg::*;
(
  input  logic                       clock,
  input  logic                       reset_n,
  exp7_unidade_controle_if.master    uc
);

  state_e state_q, state_d;

  // Timeout only matters when the feature is built in; otherwise waits are unbounded.
  logic timeout_hit;
`ifdef EXP7_UC_TIMEOUT_EN
  assign timeout_hit = uc.timeout;
`else
  assign timeout_hit = 1'b0;
`endif

  // State register; reset lands in inicial so every decoded output drops at once.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= S_INICIAL;
    else          state_q <= state_d;
  end

  // Next-state logic; iniciar is only honoured in inicial and the terminal states.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_INICIAL:        if (uc.iniciar) state_d = S_PREPARACAO;
      S_PREPARACAO:     state_d = S_INICIO_RODADA;
      S_INICIO_RODADA:  state_d = S_MOSTRA_LED;
      S_MOSTRA_LED: begin
        if (uc.leds_fim) state_d = uc.enderecoIgualRodada ? S_FIM_EXIBICAO : S_PROXIMO_LED;
      end
      S_PROXIMO_LED:    state_d = S_MOSTRA_LED;
      S_FIM_EXIBICAO:   state_d = S_ESPERA_JOGADA;
      S_ESPERA_JOGADA: begin
        if (uc.jogada_feita)  state_d = S_REGISTRA;
        else if (timeout_hit) state_d = S_FIM_TIMEOUT;
      end
      S_REGISTRA:       state_d = S_COMPARACAO;
      S_COMPARACAO: begin
        if (!uc.jogada_correta)                    state_d = S_FIM_ERROU;
        else if (uc.enderecoIgualRodada && uc.fimL) state_d = S_FIM_ACERTOU;
        else if (uc.enderecoIgualRodada)           state_d = S_ULTIMA_OK;
        else                                       state_d = S_PROXIMA_JOGADA;
      end
      S_PROXIMA_JOGADA: state_d = S_ESPERA_JOGADA;
      S_ULTIMA_OK:      state_d = S_ESPERA_NOVA;
      S_ESPERA_NOVA: begin
        if (uc.jogada_feita)  state_d = S_REGISTRA_NOVA;
        else if (timeout_hit) state_d = S_FIM_TIMEOUT;
      end
      S_REGISTRA_NOVA:  state_d = S_GRAVA;
      S_GRAVA:          state_d = S_PROXIMA_RODADA;
      S_PROXIMA_RODADA: state_d = S_INICIO_RODADA;
      S_FIM_ACERTOU, S_FIM_ERROU, S_FIM_TIMEOUT: begin
        if (uc.iniciar) state_d = S_PREPARACAO;
      end
      default:          state_d = S_INICIAL;
    endcase
  end

  // Output decode from the registered state only.
  always_comb begin
    uc.zeraCR       = 1'b0;
    uc.zeraE        = 1'b0;
    uc.contaCR      = 1'b0;
    uc.contaE       = 1'b0;
    uc.limpaRC      = 1'b0;
    uc.registraRC   = 1'b0;
    uc.zeraLeds     = 1'b0;
    uc.registraLeds = 1'b0;
    uc.contaT       = 1'b0;
    uc.contaL       = 1'b0;
    uc.led_selector = 1'b0;
    uc.led_turn_off = 1'b0;
    uc.ram_enable   = 1'b0;
    uc.pronto       = 1'b0;
    uc.ganhou       = 1'b0;
    uc.perdeu       = 1'b0;
    uc.db_timeout   = 1'b0;
    case (state_q)
      S_PREPARACAO: begin
        uc.zeraCR   = 1'b1;
        uc.zeraE    = 1'b1;
        uc.limpaRC  = 1'b1;
        uc.zeraLeds = 1'b1;
      end
      S_INICIO_RODADA: begin
        uc.zeraE        = 1'b1;
        uc.registraLeds = 1'b1;
        uc.led_selector = 1'b1;
      end
      S_MOSTRA_LED:     uc.contaL = 1'b1;
      S_PROXIMO_LED:    uc.contaE = 1'b1;
      S_FIM_EXIBICAO: begin
        uc.zeraE        = 1'b1;
        uc.limpaRC      = 1'b1;
        uc.registraLeds = 1'b1;
      end
`ifdef EXP7_UC_TIMEOUT_EN
      S_ESPERA_JOGADA:  uc.contaT = 1'b1;
`endif
      S_REGISTRA:       uc.registraRC = 1'b1;
      S_PROXIMA_JOGADA: uc.contaE = 1'b1;
      S_ULTIMA_OK: begin
        uc.contaE  = 1'b1;
        uc.limpaRC = 1'b1;
      end
      S_ESPERA_NOVA: begin
`ifdef EXP7_UC_TIMEOUT_EN
        uc.contaT       = 1'b1;
`endif
        uc.led_turn_off = 1'b1;
      end
      S_REGISTRA_NOVA:  uc.registraRC = 1'b1;
      S_GRAVA:          uc.ram_enable = 1'b1;
      S_PROXIMA_RODADA: uc.contaCR = 1'b1;
      S_FIM_ACERTOU: begin
        uc.pronto = 1'b1;
        uc.ganhou = 1'b1;
      end
      S_FIM_ERROU: begin
        uc.pronto = 1'b1;
        uc.perdeu = 1'b1;
      end
      S_FIM_TIMEOUT: begin
        uc.pronto     = 1'b1;
        uc.perdeu     = 1'b1;
        uc.db_timeout = 1'b1;
      end
      default: ;
    endcase
  end

  assign uc.db_estado = state_q;

endmodule

// File: tb/tb_exp7_unidade_controle.sv
// tb/tb_exp7_unidade_controle.sv - vector-table bench for exp7_unidade_controle
module tb_exp7_unidade_controle;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  exp7_unidade_controle_if uc_if();

  exp7_unidade_controle dut (
    .clock   (clock),
    .reset_n (reset_n),
    .uc      (uc_if)
  );

  always #5 clock = ~clock;

  // Output bit order used by the expectation table below.
  logic [16:0] act_out;
  assign act_out = {uc_if.zeraCR, uc_if.zeraE, uc_if.contaCR, uc_if.contaE, uc_if.limpaRC,
                    uc_if.registraRC, uc_if.zeraLeds, uc_if.registraLeds, uc_if.contaT,
                    uc_if.contaL, uc_if.led_selector, uc_if.led_turn_off, uc_if.ram_enable,
                    uc_if.pronto, uc_if.ganhou, uc_if.perdeu, uc_if.db_timeout};

`ifdef EXP7_UC_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  // Hand-written table of asserted outputs per state code.
  function automatic logic [16:0] exp_out(input logic [4:0] st);
    logic [16:0] r;
    r = '0;
    case (st)
      5'h01: begin r[16] = 1; r[15] = 1; r[12] = 1; r[10] = 1; end
      5'h02: begin r[15] = 1; r[9] = 1; r[6] = 1; end
      5'h03: r[7] = 1;
      5'h04: r[13] = 1;
      5'h05: begin r[15] = 1; r[12] = 1; r[9] = 1; end
      5'h06: r[8] = TO_EN;
      5'h07: r[11] = 1;
      5'h09: r[13] = 1;
      5'h0A: begin r[13] = 1; r[12] = 1; end
      5'h0B: begin r[8] = TO_EN; r[5] = 1; end
      5'h0C: r[11] = 1;
      5'h0D: r[4] = 1;
      5'h0E: r[14] = 1;
      5'h10: begin r[3] = 1; r[2] = 1; end
      5'h11: begin r[3] = 1; r[1] = 1; end
      5'h12: begin r[3] = 1; r[1] = 1; r[0] = 1; end
      default: r = '0;
    endcase
    return r;
  endfunction

  typedef struct {
    logic       ini, jc, eir, fl, jf, to, lf;
    logic [4:0] st;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic ini, jc, eir, fl, jf, to, lf, input logic [4:0] st);
    vec_t v;
    v.ini = ini; v.jc = jc; v.eir = eir; v.fl = fl; v.jf = jf; v.to = to; v.lf = lf; v.st = st;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_state(input string name, input logic [4:0] st);
    check({name, " estado"}, {27'd0, uc_if.db_estado}, {27'd0, st});
    check({name, " saidas"}, {15'd0, act_out}, {15'd0, exp_out(st)});
  endtask

  task automatic apply(input logic ini, jc, eir, fl, jf, to, lf);
    uc_if.iniciar = ini; uc_if.jogada_correta = jc; uc_if.enderecoIgualRodada = eir;
    uc_if.fimL = fl; uc_if.jogada_feita = jf; uc_if.timeout = to; uc_if.leds_fim = lf;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    check_state("reset imediato", 5'h00);
    apply(0, 0, 0, 0, 0, 0, 0);
    reset_n = 1'b1;
  endtask

  // From inicial through a one-LED replay into espera_jogada.
  task automatic goto_espera();
    apply(1, 0, 1, 0, 0, 0, 0);
    apply(0, 0, 1, 0, 0, 0, 0);
    apply(0, 0, 1, 0, 0, 0, 0);
    apply(0, 0, 1, 0, 0, 0, 1);
    apply(0, 0, 1, 0, 0, 0, 0);
    check_state("chega espera_jogada", 5'h06);
  endtask

  initial begin
    uc_if.iniciar = 0; uc_if.jogada_correta = 0; uc_if.enderecoIgualRodada = 0;
    uc_if.fimL = 0; uc_if.jogada_feita = 0; uc_if.timeout = 0; uc_if.leds_fim = 0;

    //        ini jc eir fl jf to lf  state
    add(1, 0, 0, 0, 0, 0, 0, 5'h01);
    add(0, 0, 1, 0, 0, 0, 0, 5'h02);
    add(0, 0, 1, 0, 0, 0, 0, 5'h03);
    add(1, 0, 1, 0, 0, 0, 0, 5'h03);
    add(0, 0, 1, 0, 0, 0, 1, 5'h05);
    add(0, 0, 1, 0, 0, 0, 0, 5'h06);
    add(1, 0, 1, 0, 0, 0, 0, 5'h06);
    add(0, 1, 1, 0, 1, 0, 0, 5'h07);
    add(0, 1, 1, 0, 0, 0, 0, 5'h08);
    add(0, 1, 1, 0, 0, 0, 0, 5'h0A);
    add(0, 0, 0, 0, 0, 0, 0, 5'h0B);
    add(0, 0, 0, 0, 0, 0, 0, 5'h0B);
    add(0, 0, 0, 0, 1, 0, 0, 5'h0C);
    add(0, 0, 0, 0, 0, 0, 0, 5'h0D);
    add(0, 0, 0, 0, 0, 0, 0, 5'h0E);
    add(0, 0, 0, 0, 0, 0, 0, 5'h02);
    add(0, 0, 0, 0, 0, 0, 0, 5'h03);
    add(0, 0, 0, 0, 0, 0, 1, 5'h04);
    add(0, 0, 0, 0, 0, 0, 0, 5'h03);
    add(0, 0, 1, 0, 0, 0, 1, 5'h05);
    add(0, 0, 0, 0, 0, 0, 0, 5'h06);
    add(0, 0, 0, 0, 1, 0, 0, 5'h07);
    add(0, 0, 0, 0, 0, 0, 0, 5'h08);
    add(0, 1, 0, 0, 0, 0, 0, 5'h09);
    add(0, 0, 0, 0, 0, 0, 0, 5'h06);
    add(0, 0, 0, 0, 1, 0, 0, 5'h07);
    add(0, 0, 0, 0, 0, 0, 0, 5'h08);
    add(0, 0, 1, 1, 0, 0, 0, 5'h11);
    add(0, 0, 0, 0, 1, 0, 0, 5'h11);
    add(1, 0, 0, 0, 0, 0, 0, 5'h01);
    add(0, 0, 1, 0, 0, 0, 0, 5'h02);
    add(0, 0, 1, 0, 0, 0, 0, 5'h03);
    add(0, 0, 1, 0, 0, 0, 1, 5'h05);
    add(0, 0, 1, 0, 0, 0, 0, 5'h06);
    add(0, 1, 1, 1, 1, 0, 0, 5'h07);
    add(0, 1, 1, 1, 0, 0, 0, 5'h08);
    add(0, 1, 1, 1, 0, 0, 0, 5'h10);
    add(0, 0, 0, 0, 0, 0, 0, 5'h10);
    add(1, 0, 0, 0, 0, 0, 0, 5'h01);

    // Reset state, then idle with iniciar low.
    apply(0, 0, 0, 0, 0, 0, 0);
    check_state("em reset", 5'h00);
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      apply(0, 0, 0, 0, 0, 0, 0);
      check_state("ocioso", 5'h00);
    end

    // Full game walk from the vector table.
    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i].ini, vecs[i].jc, vecs[i].eir, vecs[i].fl, vecs[i].jf, vecs[i].to, vecs[i].lf);
      check_state($sformatf("vetor %0d", i), vecs[i].st);
    end

    // Move and timeout together: the move wins; then timeout in espera_nova.
    do_reset();
    goto_espera();
    apply(0, 0, 0, 0, 1, 1, 0);
    check_state("jogada vence timeout", 5'h07);
    apply(0, 1, 1, 0, 0, 0, 0);
    apply(0, 1, 1, 0, 0, 0, 0);
    apply(0, 0, 0, 0, 0, 0, 0);
    check_state("espera_nova", 5'h0B);
    apply(0, 0, 0, 0, 0, 1, 0);
    check_state("timeout espera_nova", TO_EN ? 5'h12 : 5'h0B);

    // Asynchronous reset while grava is driving ram_enable.
    do_reset();
    goto_espera();
    apply(0, 0, 0, 0, 1, 0, 0);
    apply(0, 1, 1, 0, 0, 0, 0);
    apply(0, 1, 1, 0, 0, 0, 0);
    apply(0, 0, 0, 0, 0, 0, 0);
    apply(0, 0, 0, 0, 1, 0, 0);
    apply(0, 0, 0, 0, 0, 0, 0);
    check_state("grava", 5'h0D);
    reset_n = 1'b0;
    #1;
    check("ram_enable no reset", {31'd0, uc_if.ram_enable}, 32'd0);
    check_state("reset em grava", 5'h00);
    apply(0, 0, 0, 0, 0, 0, 0);
    check("ram_enable reset mantido", {31'd0, uc_if.ram_enable}, 32'd0);
    reset_n = 1'b1;

    // Timeout alone in espera_jogada, then reset mid-wait.
    goto_espera();
    apply(0, 0, 0, 0, 0, 1, 0);
    check_state("timeout espera_jogada", TO_EN ? 5'h12 : 5'h06);
    check("contaT", {31'd0, uc_if.contaT}, {31'd0, (TO_EN ? 1'b0 : 1'b0)});
    do_reset();
    apply(0, 0, 0, 0, 0, 0, 0);
    check_state("apos reset", 5'h00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
